multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: a single state register with combinationally
// decoded datapath strobes for FETCH/DECODE/EXEC/MEM/WB and a sticky TRAP.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        MemReq,
  output logic        MemRW,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSel,
  output logic        RegWEn,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic [1:0]  WBSel,
  output logic [3:0]  ALUSel,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [4:0] OpR      = 5'b01100;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluSll  = 4'b0010;
  localparam logic [3:0] AluSlt  = 4'b0011;
  localparam logic [3:0] AluSltu = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluAnd  = 4'b1001;

  localparam logic [1:0] WbMem = 2'b00;
  localparam logic [1:0] WbAlu = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr;
  logic       legal;
  logic       br_taken;
  logic [3:0] alu_arith;

  // Fields the control path never looks at (rd, rs1, rs2, most of imm, length bits).
  logic unused_inst;
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7], inst[1:0]};

  assign opcode = inst[6:2];
  assign funct3 = inst[14:12];
  assign alt    = inst[30];

  assign is_r      = (opcode == OpR);
  assign is_imm    = (opcode == OpImm);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);

  // Branch funct3 010/011 are reserved encodings.
  assign legal = is_r | is_imm | is_load | is_store | is_jal | is_jalr |
                 (is_branch & (funct3[2:1] != 2'b01));

  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = ~BrEq;
      3'b100, 3'b110: br_taken = BrLt;
      3'b101, 3'b111: br_taken = ~BrLt;
      default:        br_taken = 1'b0;
    endcase
  end

  // inst[30] selects sub only for R-type; it always selects sra on a right shift.
  always_comb begin
    alu_arith = AluAdd;
    unique case (funct3)
      3'b000:  alu_arith = (is_r && alt) ? AluSub : AluAdd;
      3'b001:  alu_arith = AluSll;
      3'b010:  alu_arith = AluSlt;
      3'b011:  alu_arith = AluSltu;
      3'b100:  alu_arith = AluXor;
      3'b101:  alu_arith = alt ? AluSra : AluSrl;
      3'b110:  alu_arith = AluOr;
      3'b111:  alu_arith = AluAnd;
      default: alu_arith = AluAdd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: state_d = legal ? StExec : StTrap;
      StExec: begin
        if (is_load || is_store) state_d = StMem;
        else if (is_branch)      state_d = StFetch;
        else                     state_d = StWb;
      end
      StMem:    if (mem_ready) state_d = is_load ? StWb : StFetch;
      StWb:     state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  logic       mem_req_c, mem_rw_c, iord_c, ir_write_c, pc_write_c, pc_sel_c;
  logic       reg_wen_c, br_un_c, a_sel_c, b_sel_c, done_c;
  logic [1:0] wb_sel_c;
  logic [3:0] alu_sel_c;

  always_comb begin
    mem_req_c  = 1'b0;
    mem_rw_c   = 1'b0;
    iord_c     = 1'b0;
    ir_write_c = 1'b0;
    pc_write_c = 1'b0;
    pc_sel_c   = 1'b0;
    reg_wen_c  = 1'b0;
    br_un_c    = 1'b0;
    a_sel_c    = 1'b0;
    b_sel_c    = 1'b0;
    done_c     = 1'b0;
    wb_sel_c   = WbAlu;
    alu_sel_c  = AluAdd;
    unique case (state_q)
      StFetch: begin
        mem_req_c  = 1'b1;
        ir_write_c = mem_ready;
      end
      StExec: begin
        alu_sel_c = (is_r || is_imm) ? alu_arith : AluAdd;
        b_sel_c   = ~(is_r | is_branch);
        a_sel_c   = is_branch | is_jal;
        if (is_branch) begin
          pc_write_c = 1'b1;
          done_c     = 1'b1;
          pc_sel_c   = br_taken;
          br_un_c    = funct3[2] & funct3[1];
        end
      end
      StMem: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_rw_c  = is_store;
        if (mem_ready && is_store) begin
          pc_write_c = 1'b1;
          done_c     = 1'b1;
        end
      end
      StWb: begin
        reg_wen_c  = 1'b1;
        pc_write_c = 1'b1;
        done_c     = 1'b1;
        pc_sel_c   = is_jal | is_jalr;
        if (is_load)                wb_sel_c = WbMem;
        else if (is_jal || is_jalr) wb_sel_c = WbPc4;
        else                        wb_sel_c = WbAlu;
      end
      default: ;
    endcase
  end

  // Reset is asynchronous, so strobes are masked directly rather than via state.
  assign state      = state_q;
  assign MemReq     = mem_req_c  & ~rst;
  assign MemRW      = mem_rw_c   & ~rst;
  assign IorD       = iord_c     & ~rst;
  assign IRWrite    = ir_write_c & ~rst;
  assign PCWrite    = pc_write_c & ~rst;
  assign PCSel      = pc_sel_c   & ~rst;
  assign RegWEn     = reg_wen_c  & ~rst;
  assign BrUn       = br_un_c    & ~rst;
  assign ASel       = a_sel_c    & ~rst;
  assign BSel       = b_sel_c    & ~rst;
  assign instr_done = done_c     & ~rst;
  assign WBSel      = wb_sel_c;
  assign ALUSel     = alu_sel_c;
  assign illegal    = (state_q == StTrap) & ~rst;

endmodule
